// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive and transmit halves:
//     - state_t    : FSM state encoding (PARITY is only entered when the
//                    parity build is selected)
//     - OVERSAMPLE : ticks per bit period (16x oversampling)
//     - MID_START  : tick index that lands in the middle of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_START  = 7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input. The reset value is
//   a parameter so idle-high lines (UART rx) do not see a false edge when
//   reset is released.
//
//   Ports
//     clk   : destination clock
//     reset : asynchronous, active-high reset (both flops load RESET_VAL)
//     d     : asynchronous input
//     q     : synchronized output, 2 clk after d
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= RESET_VAL;
         sync_p1 <= RESET_VAL;
      end else begin
         // stage 0: may go metastable; stage 1: settled copy
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive half of the UART. Deserialises an asynchronous 8N1 line (8E1 when
//   UART_RX_PARITY_EN is defined) into parallel words using the shared 16x
//   oversampling tick. Every completed frame raises rx_done_tick for one clk
//   together with dout and the per-frame error flags; frames with errors are
//   still delivered.
//
//   Build option
//     UART_RX_PARITY_EN : adds a PARITY state and even-parity check; without
//                         it parity_err is tied to 0.
//
//   Parameters
//     DBIT    : data bits per frame
//     SB_TICK : oversampling ticks in the stop interval (16 = 1, 32 = 2 bits)
//
//   Ports
//     clk          : system clock
//     reset        : asynchronous, active-high reset
//     rx           : serial line, asynchronous to clk, idle high
//     s_tick       : one-clk pulse at 16x baud rate
//     dout         : last received word (LSB first on the line)
//     rx_done_tick : one-clk pulse when a frame completes
//     frame_err    : stop bit of the last frame sampled low
//     parity_err   : parity mismatch on the last frame
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);
   localparam logic [4:0]    MID_TICK  = 5'(MID_START);
   localparam logic [4:0]    BIT_TICK  = 5'(OVERSAMPLE - 1);
   localparam logic [4:0]    STOP_TICK = 5'(SB_TICK - 1);

   state_t          state_reg;
   logic [4:0]      s_reg;
   logic [NW-1:0]   n_reg;
   logic [DBIT-1:0] b_reg;
   logic            rx_s;
   logic [DBIT:0]   shift_in;

   // rx crosses into the clk domain here; idle-high reset value avoids a
   // phantom start bit right after reset
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // new bit enters at the MSB so the first (LSB) bit ends up in bit 0
   assign shift_in = {rx_s, b_reg};

`ifdef UART_RX_PARITY_EN
   logic par_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         s_reg        <= '0;
         n_reg        <= '0;
         b_reg        <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         par_reg      <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (state_reg)
            IDLE: begin
               // start detection is not tick-gated, so a start bit right after
               // the stop sample loses no tick
               if (!rx_s) begin
                  state_reg <= START;
                  s_reg     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_reg == MID_TICK) begin
                     if (!rx_s) begin
                        state_reg <= DATA;
                        s_reg     <= '0;
                        n_reg     <= '0;
                     end else begin
                        // line back high mid start bit: glitch, outputs untouched
                        state_reg <= IDLE;
                     end
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_reg == BIT_TICK) begin
                     s_reg <= '0;
                     b_reg <= shift_in[DBIT:1];
                     if (n_reg == LAST_BIT) begin
                        state_reg <= PARITY;
                     end else begin
                        n_reg <= n_reg + NW'(1);
                     end
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_reg == BIT_TICK) begin
                     s_reg     <= '0;
                     // even parity: data plus parity bit must XOR to 0
                     par_reg   <= ^shift_in;
                     state_reg <= STOP;
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_reg == STOP_TICK) begin
                     dout         <= b_reg;
                     frame_err    <= ~rx_s;
                     parity_err   <= par_reg;
                     rx_done_tick <= 1'b1;
                     state_reg    <= IDLE;
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
`else
   assign parity_err = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         s_reg        <= '0;
         n_reg        <= '0;
         b_reg        <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (state_reg)
            IDLE: begin
               // start detection is not tick-gated, so a start bit right after
               // the stop sample loses no tick
               if (!rx_s) begin
                  state_reg <= START;
                  s_reg     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_reg == MID_TICK) begin
                     if (!rx_s) begin
                        state_reg <= DATA;
                        s_reg     <= '0;
                        n_reg     <= '0;
                     end else begin
                        // line back high mid start bit: glitch, outputs untouched
                        state_reg <= IDLE;
                     end
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_reg == BIT_TICK) begin
                     s_reg <= '0;
                     b_reg <= shift_in[DBIT:1];
                     if (n_reg == LAST_BIT) begin
                        state_reg <= STOP;
                     end else begin
                        n_reg <= n_reg + NW'(1);
                     end
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_reg == STOP_TICK) begin
                     dout         <= b_reg;
                     frame_err    <= ~rx_s;
                     rx_done_tick <= 1'b1;
                     state_reg    <= IDLE;
                  end else begin
                     s_reg <= s_reg + 5'd1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // ticks from the start-bit falling edge to the stop-bit sample
   localparam int F_TICKS = 8 + 16 * (DBIT + PAR_BITS + 1);

   typedef struct packed {
      logic [DBIT-1:0] d;
      logic            fe;
      logic            pe;
   } frame_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            rx = 1'b1;
   logic            s_tick = 1'b0;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;
   logic            parity_err;

   int     dvsr = 4;
   int     tick_div = 0;
   int     tick_cnt = 0;
   int     pulses = 0;
   int     checks = 0;
   int     errors = 0;
   frame_t got_q[$];
   frame_t exp_q[$];
   frame_t last_exp = '0;

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .parity_err   (parity_err)
   );

   always #5 clk = ~clk;

   // baud tick: one clk high every dvsr+1 clks
   always @(negedge clk) begin
      if (tick_div >= dvsr) begin
         tick_div = 0;
         s_tick   = 1'b1;
         tick_cnt = tick_cnt + 1;
      end else begin
         tick_div = tick_div + 1;
         s_tick   = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rx_done_tick === 1'b1) begin
         got_q.push_back(frame_t'{d: dout, fe: frame_err, pe: parity_err});
         pulses = pulses + 1;
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic wait_ticks(input int n);
      int target;
      target = tick_cnt + n;
      wait (tick_cnt >= target);
   endtask

   // Drives one frame and records what the receiver should report for it.
   // A bad stop bit is low only through its sample point so the line
   // returns high before a new start bit could be validated.
   task automatic send_frame(input logic [DBIT-1:0] data, input bit stop_ok,
                             input bit par_flip, input int idle_ticks);
      frame_t e;
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < DBIT; i++) begin
         rx = data[i];
         wait_ticks(16);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^data) ^ par_flip;
      wait_ticks(16);
      e.pe = par_flip;
`else
      e.pe = 1'b0;
`endif
      if (stop_ok) begin
         rx = 1'b1;
         wait_ticks(16);
      end else begin
         rx = 1'b0;
         wait_ticks(10);
         rx = 1'b1;
         wait_ticks(22);
      end
      e.d  = data;
      e.fe = !stop_ok;
      exp_q.push_back(e);
      last_exp = e;
      rx = 1'b1;
      if (idle_ticks > 0) wait_ticks(idle_ticks);
   endtask

   task automatic test_reset();
      rx = 1'b1;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
      checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", rx_done_tick); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
   endtask

   task automatic test_single_frame();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      dvsr = 54;
      wait_ticks(4);
      send_frame(8'h55, 1'b1, 1'b0, 16);
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL single_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL single_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   task automatic test_random_frames();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      for (int i = 0; i < 16; i++)
         send_frame(DBIT'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 24));
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL random_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL random_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   task automatic test_back_to_back();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      send_frame(8'hA3, 1'b1, 1'b0, 0);
      send_frame(8'h0F, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) send_frame(DBIT'($urandom), 1'b1, 1'b0, 0);
      wait_ticks(8);
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL b2b_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL b2b_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   task automatic test_glitch();
      frame_t e, g, held;
      int p0, len;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      held = last_exp;
      for (int k = 0; k < 3; k++) begin
         len = (k == 0) ? 4 : $urandom_range(1, 6);
         rx = 1'b0;
         wait_ticks(len);
         rx = 1'b1;
         wait_ticks(40);
         checks++;
         if (pulses != p0) begin errors++; $display("FAIL glitch_pulse len=%0d got %0d pulses want 0", len, pulses - p0); end
         g = frame_t'{d: dout, fe: frame_err, pe: parity_err};
         checks++;
         if (g !== held) begin errors++; $display("FAIL glitch_hold got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, held.d, held.fe, held.pe); end
      end
      send_frame(DBIT'($urandom), 1'b1, 1'b0, 8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL glitch_after got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   task automatic test_frame_err();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      send_frame(8'h81, 1'b0, 1'b0, 8);
      send_frame(8'h7E, 1'b1, 1'b0, 8);
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL ferr_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL ferr_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      send_frame(8'h03, 1'b1, 1'b0, 8);
      send_frame(8'h03, 1'b1, 1'b1, 8);
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL parity_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL parity_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask
`endif

   // Line held low: two all-zero frames with framing errors, then the line
   // rises between the third frame's start check and its first data sample,
   // so that frame reads all ones with a good stop bit.
   task automatic test_break();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete(); p0 = pulses;
      rx = 1'b0;
      wait_ticks(2 * F_TICKS + 16);
      rx = 1'b1;
      wait_ticks(F_TICKS + 16);
      exp_q.push_back(frame_t'{d: '0, fe: 1'b1, pe: 1'b0});
      exp_q.push_back(frame_t'{d: '0, fe: 1'b1, pe: 1'b0});
      exp_q.push_back(frame_t'{d: '1, fe: 1'b0, pe: (PAR_BITS == 1) ? ((^8'hFF) ^ 1'b1) : 1'b0});
      last_exp = exp_q[2];
      checks++;
      if (pulses - p0 != exp_q.size()) begin errors++; $display("FAIL break_pulses got %0d want %0d", pulses - p0, exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL break_frame got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   task automatic test_reset_midframe();
      frame_t e, g;
      int p0;
      got_q.delete(); exp_q.delete();
      send_frame(8'hA5, 1'b0, 1'b1, 8);
      exp_q.delete(); got_q.delete();
      p0 = pulses;
      rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         wait_ticks(16);
      end
      wait_ticks(8);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (dout !== '0) begin errors++; $display("FAIL midrst_dout got %h want 00", dout); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL midrst_parity_err got %b want 0", parity_err); end
      reset = 1'b0;
      wait_ticks(8 + 16 * (3 + PAR_BITS + 1) + 16);
      checks++;
      if (pulses != p0) begin errors++; $display("FAIL midrst_pulse got %0d pulses want 0", pulses - p0); end
      checks++; if (dout !== '0) begin errors++; $display("FAIL midrst_hold_dout got %h want 00", dout); end
      send_frame(8'h3C, 1'b1, 1'b0, 8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
         checks++;
         if (g !== e) begin errors++; $display("FAIL midrst_after got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      dvsr = $urandom_range(3, 6);
      wait_ticks(2);
      test_random_frames();
      test_back_to_back();
      test_glitch();
      test_frame_err();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_break();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART: deserialises an asynchronous 8N1 (optionally 8E1) line into parallel bytes using the shared 16× oversampling tick from `baud_rate_generator`. It sits beside `uart_tx` in the `uart` top. Each completed frame raises a one-cycle `rx_done_tick`, which the top uses as the write strobe of a receive `fifo_16x8`, together with `dout` and per-frame error flags.

## Interface

**Parameters**
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks in the stop interval (16 = 1 stop bit, 32 = 2 stop bits).

**Ports**
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `rx`, input, 1: serial line; asynchronous to `clk`; idle high.
- `s_tick`, input, 1: one-`clk` pulse at 16× baud rate.
- `dout`, output, DBIT: last received data word, LSB first on the line.
- `rx_done_tick`, output, 1: one-cycle pulse when a frame completes.
- `frame_err`, output, 1: stop bit of the last frame sampled low.
- `parity_err`, output, 1: parity mismatch on the last frame.

## Operation

- `rx` passes through a two-flop synchronizer, which resets to 1. The FSM sees only the synchronized `rx_s`.
- Counters:
  - `s_reg`, 5 bits: counts ticks within a bit, wide enough for `SB_TICK` up to 32.
  - `n_reg`, width `$clog2(DBIT)`: counts data bits.
  - `b_reg`, DBIT: shift register.
- FSM states: `IDLE`, `START`, `DATA`, `PARITY` (present only with the macro), `STOP`.
  - **IDLE:** when `rx_s` is 0, go to `START` and set `s_reg` to 0. Ticks are ignored.
  - **START:** on each `s_tick`, increment `s_reg`. On the tick where `s_reg` is 7 (mid start bit):
    - if `rx_s` is 0, go to `DATA` with `s_reg` and `n_reg` set to 0;
    - if `rx_s` is 1, treat it as a glitch and return to `IDLE` with no pulse and no flag change.
  - **DATA:** on the tick where `s_reg` is 15, shift `rx_s` into the MSB of `b_reg` (right shift, so the LSB arrives first) and set `s_reg` to 0. After bit `DBIT-1` is captured, go to `PARITY` (macro set) or `STOP`; otherwise increment `n_reg`.
  - **PARITY:** on the tick where `s_reg` is 15, compute `par_err` as the XOR of `rx_s` and every bit of `b_reg` (even parity), then go to `STOP`.
  - **STOP:** on the tick where `s_reg` is `SB_TICK-1`:
    - load `dout` from `b_reg`;
    - load `frame_err` with `~rx_s`;
    - load `parity_err`;
    - pulse `rx_done_tick`;
    - return to `IDLE`.
- `dout`, `frame_err` and `parity_err` hold their values until the next frame completes. Glitch rejection does not alter them.
- The frame is always delivered, even if it has an error; the consumer decides what to do with it.

**Reset values**
- State: `IDLE`.
- `s_reg`, `n_reg`, `b_reg`: 0.
- `dout`: 0.
- `rx_done_tick`, `frame_err`, `parity_err`: 0.
- Synchronizer flops: 1.

**Reset mid-frame:** the partial frame is discarded, outputs return to their reset values, and the next falling edge starts a new frame.

## Timing

- Pin to FSM latency is 2 `clk`, from the synchronizer.
- `rx_done_tick` is registered. It is high for exactly the one `clk` after the final stop-bit `s_tick`, and `dout` and the error flags are valid in that same cycle.
- The receiver is back in `IDLE` in that same cycle, so a start bit that immediately follows the stop interval is accepted. This gives back-to-back frames with no lost tick.
- `s_tick` is asserted for at most one `clk` per 16 ticks of bit time. The block does not require any spacing between ticks beyond 1 `clk`.
- A continuous break (`rx` held at 0) produces a frame with `dout` = 0 and `frame_err` = 1, then one new frame per frame time while the line stays low.

## Configuration

- **`UART_RX_PARITY_EN` defined:** the `PARITY` state and even-parity check are compiled in, and the frame is start + DBIT + parity + stop.
- **`UART_RX_PARITY_EN` not defined:** there is no `PARITY` state, `DATA` goes directly to `STOP`, and `parity_err` is tied to 0.
- The top must define the macro consistently with the `uart_tx` build.

## Structure

- Shared package `uart_pkg` holds:
  - the FSM state encoding, shared with `uart_tx`;
  - the constants `OVERSAMPLE` = 16 and `MID_START` = 7.
- Sub-module `sync_2ff` provides the two-flop synchronizer with a parameterised reset value (1 here). It is reusable for other asynchronous inputs.
- The `uart` top adds a `fifo_16x8` on the receive side, with `wr` driven by `rx_done_tick`, plus the `rd_uart`, `r_data` and `rx_empty` ports.

## Test plan

1. **Single frame:** with DVSR = 54, drive 0x55 as 8N1 at baud. Expect one `rx_done_tick`, `dout` = 0x55, `frame_err` = 0, `parity_err` = 0.
2. **Back-to-back frames:** drive 0xA3 then 0x0F with no idle between them. Expect two pulses with `dout` = 0xA3 then 0x0F, and no missed start bit.
3. **Glitch rejection:** drive `rx` low for 4 tick periods, then high. Expect no `rx_done_tick`, state back in `IDLE`, and earlier `dout` and flags unchanged.
4. **Framing error:** send 0x81 with the stop bit forced low. Expect `dout` = 0x81, `frame_err` = 1, then a clean frame 0x7E clears `frame_err` to 0.
5. **Parity (with `UART_RX_PARITY_EN`):**
   - 0x03 with parity bit 0: `parity_err` = 0;
   - 0x03 with parity bit 1: `parity_err` = 1.
6. **Reset mid-frame:** assert `reset` during data bit 4 of 0xFF. Expect all outputs at 0, no pulse, and a following 0x3C received correctly.
